// File: rtl/rv32_lsu_pkg.sv
// Shared memory-op definitions for the RV32 data path.
// Width codes, LSU fault causes and LSU FSM states.
package rv32_mem_ops;

    localparam logic [1:0] RV32_MEM_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] RV32_MEM_WIDTH_HALF = 2'd1;
    localparam logic [1:0] RV32_MEM_WIDTH_WORD = 2'd2;

    typedef enum logic [1:0] {
        RV32_LSU_FAULT_NONE       = 2'd0,
        RV32_LSU_FAULT_MISALIGNED = 2'd1,
        RV32_LSU_FAULT_TIMEOUT    = 2'd2
    } rv32_lsu_fault_t;

    typedef enum logic [1:0] {
        RV32_LSU_IDLE = 2'd0,
        RV32_LSU_BUS  = 2'd1,
        RV32_LSU_DONE = 2'd2
    } rv32_lsu_state_t;

endpackage

// File: rtl/rv32_lsu_if.sv
// Data-bus request/response bundle between the LSU and memory.
// Single outstanding request, completed on valid && ready.
interface rv32_lsu_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  bus_valid_out;
    logic                  bus_write_out;
    logic [ADDR_WIDTH-3:0] bus_addr_out;
    logic [3:0]            bus_mask_out;
    logic [31:0]           bus_wdata_out;
    logic [31:0]           bus_rdata_in;
    logic                  bus_ready_in;

    modport master (
        output bus_valid_out,
        output bus_write_out,
        output bus_addr_out,
        output bus_mask_out,
        output bus_wdata_out,
        input  bus_rdata_in,
        input  bus_ready_in
    );

    modport slave (
        input  bus_valid_out,
        input  bus_write_out,
        input  bus_addr_out,
        input  bus_mask_out,
        input  bus_wdata_out,
        output bus_rdata_in,
        output bus_ready_in
    );
endinterface

// File: rtl/rv32_lsu_align.sv
// Combinational lane logic: alignment check, store steering and
// mask, load lane select with sign/zero extension (offset 0 = MSB).
module rv32_lsu_align
    import rv32_mem_ops::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  width,
    input  logic        zero_extend,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic        misaligned,
    output logic [3:0]  store_mask,
    output logic [31:0] store_lanes,
    output logic [31:0] load_value
);
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sx_b;
    logic        sx_h;

    assign byte_sh  = {~offset, 3'b000};
    assign half_sh  = {~offset[1], 4'b0000};
    assign byte_sel = load_data[byte_sh +: 8];
    assign half_sel = load_data[half_sh +: 16];
    assign sx_b     = ~zero_extend & byte_sel[7];
    assign sx_h     = ~zero_extend & half_sel[15];

    always_comb begin
        misaligned  = 1'b0;
        store_mask  = '0;
        store_lanes = '0;
        load_value  = '0;
        unique case (1'b1)
            width == RV32_MEM_WIDTH_BYTE: begin
                store_mask  = 4'b1000 >> offset;
                store_lanes = {24'd0, store_data[7:0]} << byte_sh;
                load_value  = {{24{sx_b}}, byte_sel};
            end
            width == RV32_MEM_WIDTH_HALF: begin
                misaligned  = offset[0];
                store_mask  = 4'b1100 >> {offset[1], 1'b0};
                store_lanes = {16'd0, store_data[15:0]} << half_sh;
                load_value  = {{16{sx_h}}, half_sel};
            end
            width == RV32_MEM_WIDTH_WORD: begin
                misaligned  = |offset;
                store_mask  = 4'b1111;
                store_lanes = store_data;
                load_value  = load_data;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32_lsu.sv
// Memory-stage load/store unit: multi-cycle bus master that stalls
// the pipeline until the access completes, faults or times out.
module rv32_lsu
    import rv32_mem_ops::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int COUNT_WIDTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        read_en_in,
    input  logic        write_en_in,
    input  logic [1:0]  width_in,
    input  logic        zero_extend_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] rs2_value_in,
    output logic        stall_out,
    output logic        done_out,
    output logic [31:0] read_value_out,
    output logic        fault_out,
    output logic [1:0]  fault_cause_out,
    rv32_lsu_if.master  bus
);
    localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);

    rv32_lsu_state_t       state;
    rv32_lsu_state_t       state_d;
    logic [COUNT_WIDTH-1:0] cnt;
    rv32_lsu_fault_t       cause_q;
    logic [ADDR_WIDTH-3:0] addr_q;
    logic [3:0]            mask_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  write_q;
    logic [1:0]            width_q;
    logic                  zext_q;
    logic [1:0]            off_q;

    logic        mem_op;
    logic        in_idle;
    logic        in_bus;
    logic        in_done;
    logic        timeout_hit;
    logic [1:0]  al_off;
    logic [1:0]  al_width;
    logic        al_zext;
    logic        mis;
    logic [3:0]  lane_mask;
    logic [31:0] lanes;
    logic [31:0] load_value;

    assign mem_op  = valid_in && (read_en_in || write_en_in);
    assign in_idle = state == RV32_LSU_IDLE;
    assign in_bus  = state == RV32_LSU_BUS;
    assign in_done = state == RV32_LSU_DONE;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

    // Request fields feed the aligner in IDLE; the held ones after.
    assign al_off   = in_idle ? addr_in[1:0]   : off_q;
    assign al_width = in_idle ? width_in       : width_q;
    assign al_zext  = in_idle ? zero_extend_in : zext_q;

    rv32_lsu_align u_align (
        .offset      (al_off),
        .width       (al_width),
        .zero_extend (al_zext),
        .store_data  (rs2_value_in),
        .load_data   (rdata_q),
        .misaligned  (mis),
        .store_mask  (lane_mask),
        .store_lanes (lanes),
        .load_value  (load_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RV32_LSU_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= in_bus ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            RV32_LSU_IDLE: begin
                if (mem_op)
                    state_d = mis ? RV32_LSU_DONE : RV32_LSU_BUS;
            end
            RV32_LSU_BUS: begin
                if (bus.bus_ready_in || timeout_hit)
                    state_d = RV32_LSU_DONE;
            end
            RV32_LSU_DONE: state_d = RV32_LSU_IDLE;
            default:       state_d = RV32_LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cause_q <= RV32_LSU_FAULT_NONE;
            addr_q  <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            width_q <= '0;
            zext_q  <= 1'b0;
            off_q   <= '0;
        end else begin
            if (in_idle && mem_op) begin
                cause_q <= mis ? RV32_LSU_FAULT_MISALIGNED
                               : RV32_LSU_FAULT_NONE;
                addr_q  <= addr_in[ADDR_WIDTH-1:2];
                mask_q  <= write_en_in ? lane_mask : 4'b1111;
                wdata_q <= write_en_in ? lanes : '0;
                write_q <= write_en_in;
                width_q <= width_in;
                zext_q  <= zero_extend_in;
                off_q   <= addr_in[1:0];
            end
            // Ready on the timeout cycle still completes the access.
            if (in_bus) begin
                if (bus.bus_ready_in) begin
                    rdata_q <= bus.bus_rdata_in;
                    cause_q <= RV32_LSU_FAULT_NONE;
                end else if (timeout_hit) begin
                    cause_q <= RV32_LSU_FAULT_TIMEOUT;
                end
            end
        end
    end

    assign stall_out       = mem_op && !in_done;
    assign done_out        = in_done;
    assign fault_out       = in_done && (cause_q != RV32_LSU_FAULT_NONE);
    assign fault_cause_out = in_done ? cause_q : RV32_LSU_FAULT_NONE;
    assign read_value_out  =
        (in_done && !write_q && cause_q == RV32_LSU_FAULT_NONE)
        ? load_value : '0;

    assign bus.bus_valid_out = in_bus;
    assign bus.bus_write_out = in_bus && write_q;
    assign bus.bus_addr_out  = in_bus ? addr_q  : '0;
    assign bus.bus_mask_out  = in_bus ? mask_q  : '0;
    assign bus.bus_wdata_out = in_bus ? wdata_q : '0;

endmodule

// File: tb/tb_rv32_lsu.sv
// Bench for rv32_lsu: directed plan cases plus random accesses
// against a byte-addressed reference model; two timeout settings.
module tb_rv32_lsu;
    import rv32_mem_ops::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_a;
    logic        valid_b;
    logic        rd;
    logic        wr;
    logic [1:0]  width;
    logic        zext;
    logic [31:0] addr;
    logic [31:0] data;

    logic        stall_a, done_a, fault_a;
    logic        stall_b, done_b, fault_b;
    logic [31:0] rv_a, rv_b;
    logic [1:0]  cause_a, cause_b;

    int checks   = 0;
    int failures = 0;
    bit cur      = 1'b0;

    rv32_lsu_if ifa ();
    rv32_lsu_if ifb ();

    always #5 clk = ~clk;

    rv32_lsu u_dut_a (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_a),
        .read_en_in      (rd),
        .write_en_in     (wr),
        .width_in        (width),
        .zero_extend_in  (zext),
        .addr_in         (addr),
        .rs2_value_in    (data),
        .stall_out       (stall_a),
        .done_out        (done_a),
        .read_value_out  (rv_a),
        .fault_out       (fault_a),
        .fault_cause_out (cause_a),
        .bus             (ifa.master)
    );

    rv32_lsu #(.TIMEOUT_CYCLES(4)) u_dut_b (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_b),
        .read_en_in      (rd),
        .write_en_in     (wr),
        .width_in        (width),
        .zero_extend_in  (zext),
        .addr_in         (addr),
        .rs2_value_in    (data),
        .stall_out       (stall_b),
        .done_out        (done_b),
        .read_value_out  (rv_b),
        .fault_out       (fault_b),
        .fault_cause_out (cause_b),
        .bus             (ifb.master)
    );

    // Outputs of whichever instance the current access targets
    logic        s_stall, s_done, s_fault, s_bv, s_bw;
    logic [31:0] s_rv, s_wdata;
    logic [1:0]  s_cause;
    logic [29:0] s_baddr;
    logic [3:0]  s_mask;

    assign s_stall = cur ? stall_b : stall_a;
    assign s_done  = cur ? done_b  : done_a;
    assign s_fault = cur ? fault_b : fault_a;
    assign s_rv    = cur ? rv_b    : rv_a;
    assign s_cause = cur ? cause_b : cause_a;
    assign s_bv    = cur ? ifb.bus_valid_out : ifa.bus_valid_out;
    assign s_bw    = cur ? ifb.bus_write_out : ifa.bus_write_out;
    assign s_baddr = cur ? ifb.bus_addr_out  : ifa.bus_addr_out;
    assign s_mask  = cur ? ifb.bus_mask_out  : ifa.bus_mask_out;
    assign s_wdata = cur ? ifb.bus_wdata_out : ifa.bus_wdata_out;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Byte-addressed view: address offset o lives in bits 8*(3-o)+:8
    function automatic void model(
        input  logic [1:0]  wd,
        input  logic [31:0] a,
        input  logic [31:0] d,
        input  logic [31:0] rdv,
        input  bit          ze,
        output bit          mis,
        output logic [3:0]  m,
        output logic [31:0] wdat,
        output logic [31:0] ld
    );
        int s;
        int o;
        int lane;
        s = (wd == 2'd0) ? 1 : (wd == 2'd1) ? 2 : (wd == 2'd2) ? 4 : 0;
        o = int'(a[1:0]);
        m = '0;
        wdat = '0;
        ld = '0;
        if (s == 0) mis = 1'b1;
        else        mis = (o % s) != 0;
        if (!mis) begin
            for (int i = 0; i < s; i++) begin
                lane = 3 - (o + i);
                m[lane] = 1'b1;
                wdat[8*lane +: 8] = d[8*(s-1-i) +: 8];
                ld = (ld << 8) | {24'd0, rdv[8*lane +: 8]};
            end
            if (!ze && s < 4 && ld[8*s-1])
                ld = ld | (32'hFFFF_FFFF << (8*s));
        end
    endfunction

    task automatic set_ready(input bit sel, input logic r);
        if (sel) ifb.bus_ready_in = r;
        else     ifa.bus_ready_in = r;
    endtask

    // Entered and left just after a rising edge with the DUT idle.
    task automatic run_op(input bit sel, input bit w, input logic [1:0] wd,
                          input bit ze, input logic [31:0] a,
                          input logic [31:0] d, input int dly,
                          input logic [31:0] rdv);
        bit          mis;
        logic [3:0]  m;
        logic [31:0] wdat;
        logic [31:0] ld;
        int          limit;
        int          n;
        bit          ok;
        cur = sel;
        rd = !w;
        wr = w;
        width = wd;
        zext = ze;
        addr = a;
        data = d;
        valid_a = !sel;
        valid_b = sel;
        ifa.bus_rdata_in = rdv;
        ifb.bus_rdata_in = rdv;
        ifa.bus_ready_in = 1'b0;
        ifb.bus_ready_in = 1'b0;
        model(wd, a, d, rdv, ze, mis, m, wdat, ld);
        limit = sel ? 4 : 255;
        if (mis) begin
            n = 0; ok = 1'b0;
        end else if (dly >= 0 && dly <= limit) begin
            n = dly + 1; ok = 1'b1;
        end else begin
            n = limit + 1; ok = 1'b0;
        end
        @(negedge clk);
        chk("idle_stall", 32'(s_stall), 32'd1);
        chk("idle_bvalid", 32'(s_bv), 32'd0);
        chk("idle_done", 32'(s_done), 32'd0);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            set_ready(sel, k == dly);
            @(negedge clk);
            chk("bus_valid", 32'(s_bv), 32'd1);
            chk("bus_write", 32'(s_bw), 32'(w));
            chk("bus_addr", 32'(s_baddr), {2'b00, a[31:2]});
            chk("bus_mask", 32'(s_mask), w ? 32'(m) : 32'hF);
            if (w) chk("bus_wdata", s_wdata, wdat);
            chk("bus_stall", 32'(s_stall), 32'd1);
            chk("bus_done", 32'(s_done), 32'd0);
        end
        @(posedge clk);
        #1;
        set_ready(sel, 1'b0);
        @(negedge clk);
        chk("done", 32'(s_done), 32'd1);
        chk("done_stall", 32'(s_stall), 32'd0);
        chk("done_bvalid", 32'(s_bv), 32'd0);
        chk("fault", 32'(s_fault), 32'(!ok));
        chk("cause", 32'(s_cause),
            mis ? 32'(RV32_LSU_FAULT_MISALIGNED)
                : ok ? 32'(RV32_LSU_FAULT_NONE)
                     : 32'(RV32_LSU_FAULT_TIMEOUT));
        chk("read_value", s_rv, (ok && !w) ? ld : 32'd0);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_stall"}, 32'(stall_a), 32'd0);
        chk({tag, "_done"}, 32'(done_a), 32'd0);
        chk({tag, "_fault"}, 32'(fault_a), 32'd0);
        chk({tag, "_cause"}, 32'(cause_a), 32'd0);
        chk({tag, "_rv"}, rv_a, 32'd0);
        chk({tag, "_bvalid"}, 32'(ifa.bus_valid_out), 32'd0);
        chk({tag, "_bmask"}, 32'(ifa.bus_mask_out), 32'd0);
        chk({tag, "_baddr"}, 32'(ifa.bus_addr_out), 32'd0);
        chk({tag, "_bwdata"}, ifa.bus_wdata_out, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
        width = 2'd0;
        zext = 1'b0;
        addr = '0;
        data = '0;
        ifa.bus_ready_in = 1'b0;
        ifb.bus_ready_in = 1'b0;
        ifa.bus_rdata_in = '0;
        ifb.bus_rdata_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_outputs("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op(0, 1, RV32_MEM_WIDTH_WORD, 0, 32'h10, 32'hDEAD_BEEF, 0, 0);
        run_op(0, 0, RV32_MEM_WIDTH_BYTE, 0, 32'h13, 0, 0, 32'h80);
        run_op(0, 0, RV32_MEM_WIDTH_BYTE, 1, 32'h13, 0, 0, 32'h80);
        run_op(0, 1, RV32_MEM_WIDTH_HALF, 0, 32'h22, 32'h1234_ABCD, 0, 0);
        run_op(0, 0, RV32_MEM_WIDTH_HALF, 0, 32'h21, 0, 0, 32'h5555_AAAA);
        run_op(0, 0, RV32_MEM_WIDTH_HALF, 0, 32'h20, 0, 1, 32'h8001_7FFF);
        run_op(0, 1, 2'd3, 0, 32'h30, 32'h1, 0, 0);
        run_op(0, 0, RV32_MEM_WIDTH_WORD, 0, 32'h100, 0, 5, 32'hCAFE_F00D);
        run_op(0, 0, RV32_MEM_WIDTH_WORD, 0, 32'h104, 0, 0, 32'h0123_4567);
        run_op(1, 0, RV32_MEM_WIDTH_WORD, 0, 32'h200, 0, -1, 32'h1111_1111);
        run_op(1, 0, RV32_MEM_WIDTH_WORD, 0, 32'h204, 0, 4, 32'h2222_2222);
        run_op(1, 1, RV32_MEM_WIDTH_BYTE, 0, 32'h205, 32'h77, 5, 0);

        // Reset in the second BUS cycle abandons the request
        cur = 1'b0;
        rd = 1'b1;
        wr = 1'b0;
        width = RV32_MEM_WIDTH_WORD;
        addr = 32'h40;
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("pre_rst_bvalid", 32'(ifa.bus_valid_out), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_bvalid", 32'(ifa.bus_valid_out), 32'd0);
        chk("post_rst_stall", 32'(stall_a), 32'd1);
        chk("post_rst_done", 32'(done_a), 32'd0);
        valid_a = 1'b0;
        #1;
        chk("post_rst_nostall", 32'(stall_a), 32'd0);
        @(posedge clk);
        #1;
        ifa.bus_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ready_done", 32'(done_a), 32'd0);
            chk("late_ready_bvalid", 32'(ifa.bus_valid_out), 32'd0);
            ifa.bus_ready_in = 1'b0;
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            bit          sel;
            logic [1:0]  wd;
            int          dly;
            sel = 1'($urandom_range(0, 1));
            wd = ($urandom_range(0, 15) == 0) ? 2'd3
                                              : 2'($urandom_range(0, 2));
            dly = sel ? int'($urandom_range(0, 7)) - 1
                      : int'($urandom_range(0, 6));
            run_op(sel, 1'($urandom_range(0, 1)), wd,
                   1'($urandom_range(0, 1)), $urandom, $urandom,
                   dly, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32_lsu.md
Name: rv32_lsu

Overview:
Parametrised load/store unit that replaces the single-cycle on-chip data array of the memory stage with a multi-cycle bus master.
- Sits between execute and writeback.
- Steers byte lanes and generates write masks.
- Sign- or zero-extends loads.
- Stalls the pipeline until the bus completes.
- Reports misaligned accesses and bus timeouts as faults instead of performing them.

Parameters:
ADDR_WIDTH, 32, bus address width; bus_addr_out carries addr_in[ADDR_WIDTH-1:2]
TIMEOUT_CYCLES, 255, max cycles in BUS before abort with fault; 0 disables timeout
COUNT_WIDTH, 8, width of wait counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
valid_in  in  1  an instruction is present in this stage
read_en_in  in  1  load
write_en_in  in  1  store (read_en_in and write_en_in never both high)
width_in  in  2  RV32_MEM_WIDTH_BYTE/HALF/WORD
zero_extend_in  in  1  zero-extend loads (LBU/LHU)
addr_in  in  32  effective byte address
rs2_value_in  in  32  store data, right-aligned
stall_out  out  1  hold this stage and all upstream stages
done_out  out  1  one-cycle pulse; access finished (success or fault)
read_value_out  out  32  extended load data, valid with done_out
fault_out  out  1  with done_out: access not performed
fault_cause_out  out  2  RV32_LSU_FAULT_NONE/MISALIGNED/TIMEOUT
bus_valid_out  out  1  request pending
bus_write_out  out  1  1 = write
bus_addr_out  out  ADDR_WIDTH-2  word address
bus_mask_out  out  4  byte-lane write mask
bus_wdata_out  out  32  lane-steered store data
bus_rdata_in  in  32  read data, sampled when bus_ready_in
bus_ready_in  in  1  completes request in the cycle bus_valid_out && bus_ready_in

Behaviour:
- Lane convention: byte address offset 00 maps to bits 31:24 and offset 11 maps to bits 7:0. A halfword at offset 0 uses bits 31:16; at offset 2 it uses bits 15:0.
- Alignment check: HALF requires addr[0]=0. WORD requires addr[1:0]=0. BYTE is always aligned.
- Unused lanes of bus_wdata_out are driven 0, not x. A reserved width value is treated as misaligned.
- Memory op (mem_op) = valid_in && (read_en_in || write_en_in).
- stall_out = mem_op && state != DONE. This is combinational.
- FSM IDLE:
  - No mem_op: stay in IDLE.
  - mem_op, aligned: register addr, mask, wdata, write flag, width, zero_extend and addr[1:0]; go to BUS.
  - mem_op, misaligned: go to DONE with cause MISALIGNED. No bus request is issued.
- FSM BUS:
  - bus_valid_out=1 and registered request fields are held stable.
  - Wait counter increments each cycle.
  - bus_ready_in=1: capture bus_rdata_in and go to DONE with cause NONE.
  - Counter == TIMEOUT_CYCLES with no ready (TIMEOUT_CYCLES != 0): drop bus_valid_out, go to DONE with cause TIMEOUT.
  - Ready in the same cycle as timeout: ready wins.
- FSM DONE:
  - done_out=1; fault_out = (cause != NONE); read_value_out is driven.
  - Go to IDLE.
  - The pipeline advances this cycle because stall is low, so no re-accept occurs.
- Minimum latency: an aligned access with bus_ready_in high immediately has stall high for 2 cycles (IDLE, BUS) and done_out on the 3rd cycle.
- read_value_out: selected lane, extended per zero_extend. It is 0 for stores and faults and outside done_out.
- bus_mask_out: 4'b1111 for loads. For stores, the lane mask per width and offset.
- Reset (any state, including mid-BUS):
  - Next cycle: state IDLE, counter 0.
  - bus_valid_out, done_out and fault_out = 0.
  - fault_cause_out = NONE; read_value_out = 0; bus_* outputs 0.
  - The aborted bus transaction is abandoned and any late bus_ready_in is ignored.
- bus_ready_in outside BUS is ignored.

Decomposition:
- Package rv32_mem_ops (shared) holds:
  - the existing RV32_MEM_WIDTH_* constants;
  - new typedef rv32_lsu_fault_t {NONE, MISALIGNED, TIMEOUT};
  - state typedef rv32_lsu_state_t {IDLE, BUS, DONE}.
- Sub-module rv32_lsu_align is purely combinational. It performs the alignment check, store lane steering and mask generation, and load lane select and extension. It is reused by a future I-side fetch unit.

Test Plan:
- SW addr 0x0000_0010, data 0xDEAD_BEEF, ready immediately -> bus_write=1, addr=0x4, mask=1111, wdata=0xDEAD_BEEF; stall high 2 cycles; done_out with fault_out=0.
- LB addr 0x13 with rdata 0x0000_0080, zero_extend=0 -> read_value_out 0xFFFF_FF80. With LBU -> 0x0000_0080.
- SH addr 0x22, data 0x1234_ABCD -> mask=0011, wdata=0x0000_ABCD. LH addr 0x21 -> no bus_valid; done_out next cycle with fault_out=1 and cause MISALIGNED.
- LW with ready delayed 5 cycles -> bus fields stable 6 cycles, stall high throughout, done_out one cycle after ready. Back-to-back LW follows with no idle gap beyond DONE.
- TIMEOUT_CYCLES=4, ready never asserted -> bus_valid drops after counter reaches 4; cause TIMEOUT. Ready asserted exactly at count 4 -> success.
- Reset asserted in the 2nd BUS cycle -> next cycle bus_valid_out=0, stall only from the new mem_op, done_out=0. A subsequent ready pulse causes no done_out.
